qed_encoder: RTL and testbench

- Encoder side of the QED instruction path. Takes the original instruction stream, splits each word into RISC-V fields and reassembles it as the original plus a register-remapped duplicate.
- Register file is split into two halves. Originals use x0–x15; duplicates use x16–x31 (x0 stays x0).
- Sits between the instruction fetch source and the core's instruction input.
- Uses valid/ready handshakes on both sides with a one-entry registered output.

---
 rtl/qed_encoder.sv | 125 ++++++++++++
 tb/tb_qed_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_encoder.sv
// qed_encoder: splits each fetched instruction into RISC-V register fields and
// emits the original followed by a copy remapped into the x16-x31 half.
module qed_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qed_enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instruction,
  output logic             out_is_dup,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] orig_count,
  output logic [CNT_W-1:0] dup_count
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LW    = 7'b0000011;
  localparam logic [6:0]  OP_SW    = 7'b0100011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;

  typedef enum logic {S_PASS, S_DUP} state_t;

  state_t      r_state;
  logic [31:0] r_dup_buf;
  logic        r_paired;

  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_dupable;
  logic        w_illegal;
  logic [31:0] w_dup;
  logic        w_fire;
  logic        w_slot_free;
  logic        w_accept;

  // Which register fields the incoming opcode actually uses
  always_comb begin
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_dupable = 1'b1;
    case (in_instruction[6:0])
      OP_R:             begin w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_I, OP_LW:      begin w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OP_SW:            begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC: begin w_use_rd = 1'b1; end
      default:          w_dupable = 1'b0;
    endcase
  end

  // Originals may only touch x0-x15; bit 4 of a used field marks a violation
  assign w_illegal = w_dupable && ((w_use_rd  && in_instruction[11]) ||
                                   (w_use_rs1 && in_instruction[19]) ||
                                   (w_use_rs2 && in_instruction[24]));

  // Duplicate: move every nonzero used register into the upper half
  always_comb begin
    w_dup = in_instruction;
    if (w_use_rd  && (in_instruction[11:7]  != 5'd0)) w_dup[11] = 1'b1;
    if (w_use_rs1 && (in_instruction[19:15] != 5'd0)) w_dup[19] = 1'b1;
    if (w_use_rs2 && (in_instruction[24:20] != 5'd0)) w_dup[24] = 1'b1;
  end

  assign w_fire      = out_valid && out_ready;
  assign w_slot_free = !out_valid || out_ready;
  assign in_ready    = (r_state == S_PASS) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  // Control FSM, output register, sticky flag and fire counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_PASS;
      r_dup_buf       <= 32'h0;
      r_paired        <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= NOP;
      out_is_dup      <= 1'b0;
      illegal_seen    <= 1'b0;
      orig_count      <= '0;
      dup_count       <= '0;
    end else begin
      if (w_fire && r_paired)   orig_count <= orig_count + CNT_W'(1);
      if (w_fire && out_is_dup) dup_count  <= dup_count + CNT_W'(1);

      case (r_state)
        S_PASS: begin
          if (w_accept) begin
            out_valid       <= 1'b1;
            out_is_dup      <= 1'b0;
            out_instruction <= w_illegal ? NOP : in_instruction;
            r_paired        <= 1'b0;
            if (w_illegal) illegal_seen <= 1'b1;
            if (qed_enable && w_dupable && !w_illegal) begin
              r_dup_buf <= w_dup;
              r_paired  <= 1'b1;
              r_state   <= S_DUP;
            end
          end else if (w_fire) begin
            out_valid <= 1'b0;
          end
        end
        S_DUP: begin
          if (w_slot_free) begin
            out_valid       <= 1'b1;
            out_is_dup      <= 1'b1;
            out_instruction <= r_dup_buf;
            r_paired        <= 1'b0;
            r_state         <= S_PASS;
          end
        end
        default: r_state <= S_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_qed_encoder.sv
// Scoreboard bench for qed_encoder: randomized and directed instruction
// streams checked against a register-remapping reference model.
module tb_qed_encoder;

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             qed_enable;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instruction;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instruction;
  logic             out_is_dup;
  logic             illegal_seen;
  logic [CNT_W-1:0] orig_count;
  logic [CNT_W-1:0] dup_count;

  qed_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .qed_enable(qed_enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_is_dup(out_is_dup), .illegal_seen(illegal_seen),
    .orig_count(orig_count), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic        dup;
    logic        paired;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_orig = '0;
  logic [CNT_W-1:0] exp_dup = '0;
  bit               exp_illegal = 1'b0;
  bit               mon_en = 1'b0;
  bit               auto_ready = 1'b0;
  bit               hold_pending = 1'b0;
  logic [31:0]      hold_ins;
  logic             hold_dup;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned remap(input int unsigned r);
    return (r == 0) ? 0 : r + 16;
  endfunction

  // Reference: decide format, list used registers, rename them into x16-x31
  task automatic model(input logic [31:0] ins, output bit dupable, output bit illegal,
                       output logic [31:0] d);
    bit urd, urs1, urs2;
    int unsigned rd, rs1, rs2;
    rd  = 32'(ins[11:7]);
    rs1 = 32'(ins[19:15]);
    rs2 = 32'(ins[24:20]);
    case (ins[6:0])
      7'b0110011:             {dupable, urd, urs1, urs2} = 4'b1111;
      7'b0010011, 7'b0000011: {dupable, urd, urs1, urs2} = 4'b1110;
      7'b0100011:             {dupable, urd, urs1, urs2} = 4'b1011;
      7'b0110111, 7'b0010111: {dupable, urd, urs1, urs2} = 4'b1100;
      default:                {dupable, urd, urs1, urs2} = 4'b0000;
    endcase
    illegal = dupable && ((urd && rd >= 16) || (urs1 && rs1 >= 16) || (urs2 && rs2 >= 16));
    d = ins;
    if (urd)  d[11:7]  = 5'(remap(rd));
    if (urs1) d[19:15] = 5'(remap(rs1));
    if (urs2) d[24:20] = 5'(remap(rs2));
  endtask

  task automatic push_expect(input logic [31:0] ins, input logic en);
    bit dupable, illegal;
    logic [31:0] d;
    model(ins, dupable, illegal, d);
    if (illegal) begin
      sb.push_back('{ins: NOP, dup: 1'b0, paired: 1'b0});
      exp_illegal = 1'b1;
    end else if (en && dupable) begin
      sb.push_back('{ins: ins, dup: 1'b0, paired: 1'b1});
      sb.push_back('{ins: d,   dup: 1'b1, paired: 1'b0});
    end else begin
      sb.push_back('{ins: ins, dup: 1'b0, paired: 1'b0});
    end
  endtask

  // Starts and ends just after a rising edge; waits is cycles spent before accept
  task automatic send(input logic [31:0] ins, input logic en, input int budget, output int waits);
    bit done = 1'b0;
    waits = 0;
    in_instruction = ins;
    qed_enable     = en;
    in_valid       = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        push_expect(ins, en);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > budget) begin
          chk("accept_timeout", 32'(waits), 32'(budget));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Random backpressure
  always @(posedge clk) begin
    #1;
    if (auto_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: counter tracking, hold stability, scoreboard pop on every fire
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      hold_pending = 1'b0;
    end else begin
      chk("orig_count", 32'(orig_count), 32'(exp_orig));
      chk("dup_count", 32'(dup_count), 32'(exp_dup));
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_ins", out_instruction, hold_ins);
        chk("hold_dup", 32'(out_is_dup), 32'(hold_dup));
      end
      hold_pending = out_valid && !out_ready;
      hold_ins     = out_instruction;
      hold_dup     = out_is_dup;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_instruction, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_instruction", out_instruction, e.ins);
          chk("out_is_dup", 32'(out_is_dup), 32'(e.dup));
          if (e.paired) exp_orig = exp_orig + CNT_W'(1);
          if (e.dup)    exp_dup  = exp_dup + CNT_W'(1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] r;
    rst = 1'b1; qed_enable = 1'b0; in_valid = 1'b0; in_instruction = 32'h0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ins", out_instruction, NOP);
    chk("rst_out_is_dup", 32'(out_is_dup), 32'd0);
    chk("rst_illegal", 32'(illegal_seen), 32'd0);
    chk("rst_orig", 32'(orig_count), 32'd0);
    chk("rst_dup", 32'(dup_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // ADD x3,x1,x2 pair; in_ready low for exactly one cycle
    send(32'h002081B3, 1'b1, 10, w);
    @(negedge clk); chk("dup_cycle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); chk("after_dup_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drain(20);
    chk("add_orig_count", 32'(orig_count), 32'd1);
    chk("add_dup_count", 32'(dup_count), 32'd1);

    // ADDI x5,x0,7: x0 stays put in the duplicate
    send(32'h00700293, 1'b1, 10, w);
    drain(20);

    // ADD x17,x1,x2: single NOP, sticky flag, counters untouched
    send(32'h002088B3, 1'b1, 10, w);
    drain(20);
    chk("illegal_seen", 32'(illegal_seen), 32'd1);
    chk("illegal_orig_count", 32'(orig_count), 32'd2);
    chk("illegal_dup_count", 32'(dup_count), 32'd2);

    // Backpressure: original held three cycles, then duplicate follows
    out_ready = 1'b0;
    send(32'h002081B3, 1'b1, 10, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_ins", out_instruction, 32'h002081B3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("release_orig", out_instruction, 32'h002081B3);
    @(negedge clk);
    chk("release_dup_ins", out_instruction, 32'h012889B3);
    chk("release_dup_flag", 32'(out_is_dup), 32'd1);
    @(posedge clk); #1;
    drain(20);

    // Non-duplicated words back to back
    send(32'h00208463, 1'b1, 10, w);
    chk("beq_wait", 32'(w), 32'd0);
    send(32'h002081B3, 1'b0, 10, w);
    chk("add_noen_wait", 32'(w), 32'd0);
    drain(20);

    // Reset while a duplicate is pending
    out_ready = 1'b0;
    send(32'h002081B3, 1'b1, 10, w);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ins", out_instruction, NOP);
    chk("mid_rst_orig", 32'(orig_count), 32'd0);
    chk("mid_rst_dup", 32'(dup_count), 32'd0);
    chk("mid_rst_illegal", 32'(illegal_seen), 32'd0);
    sb.delete();
    exp_orig = '0; exp_dup = '0; exp_illegal = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    mon_en = 1'b1;
    send(32'h002081B3, 1'b1, 10, w);
    chk("post_rst_wait", 32'(w), 32'd0);
    drain(20);
    chk("post_rst_orig", 32'(orig_count), 32'd1);
    chk("post_rst_dup", 32'(dup_count), 32'd1);

    // Randomized stream with random enable and backpressure
    auto_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops [10];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
              7'b0010111, 7'b1100011, 7'b1101111, 7'b1110011, 7'b0000000};
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      if (n % 10 == 9) r[6:0] = 7'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        r[11] = 1'b0; r[19] = 1'b0; r[24] = 1'b0;
      end
      send(r, 1'($urandom_range(0, 1)), 40, w);
    end
    auto_ready = 1'b0;
    out_ready  = 1'b1;
    drain(200);
    chk("final_orig", 32'(orig_count), 32'(exp_orig));
    chk("final_dup", 32'(dup_count), 32'(exp_dup));
    chk("final_illegal", 32'(illegal_seen), 32'(exp_illegal));
    chk("final_pair_balance", 32'(orig_count), 32'(dup_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
